// File: rtl/disp_share_sched.sv
// Round-robin time-share scheduler for the shared 8-digit seven-segment display.
// Grants one requesting source at a time, rotating every DWELL ticks, with manual advance and hold.
module disp_share_sched #(
    parameter int N     = 4,
    parameter int DWELL = 2,
    parameter int SW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [N-1:0]  req,
    input  logic          btn_next,
    input  logic          hold,
    output logic [SW-1:0] sel,
    output logic [N-1:0]  gnt,
    output logic          blank,
    output logic          switched
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d, adv_state;
    logic [SW-1:0] last_q, last_d, sel_d;
    logic [7:0]    dwell_q, dwell_d;
    logic [N-1:0]  gnt_d;
    logic          blank_d, switched_d;

    logic          cand_found, do_adv, expire;
    logic [SW-1:0] cand_idx, scan_idx;

    assign expire = (dwell_q == 8'(DWELL - 1));

    // Scan from last+1 with wrap; the showing source is skipped so it only
    // survives an advance when it is the sole requester.
    always_comb begin
        // NOTE: every variable gets a default before the loop/case so no latch is inferred.
        cand_found = 1'b0;
        cand_idx   = sel;
        scan_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            scan_idx = SW'((int'(last_q) + k) % N);
            if (!cand_found && req[scan_idx] && (state_q == IDLE || scan_idx != sel)) begin
                cand_found = 1'b1;
                cand_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel;
        last_d     = last_q;
        dwell_d    = dwell_q;
        switched_d = 1'b0;
        do_adv     = 1'b0;
        adv_state  = SHOW;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = SHOW;
                    sel_d      = cand_idx;
                    last_d     = cand_idx;
                    dwell_d    = '0;
                    switched_d = 1'b1;
                end
            end
            SHOW: begin
                if (hold && req[sel]) begin
                    state_d = HOLD;
                end else if (hold || btn_next || !req[sel] || (tick && expire)) begin
                    do_adv    = 1'b1;
                    adv_state = hold ? HOLD : SHOW;
                end else if (tick) begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            HOLD: begin
                if (!req[sel]) begin
                    do_adv    = 1'b1;
                    adv_state = hold ? HOLD : SHOW;
                end else if (!hold) begin
                    state_d = SHOW;
                    dwell_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // One advance per cycle no matter how many triggers coincide.
        if (do_adv) begin
            dwell_d = '0;
            if (cand_found) begin
                state_d    = adv_state;
                sel_d      = cand_idx;
                last_d     = cand_idx;
                switched_d = 1'b1;
            end else if (req[sel]) begin
                state_d = adv_state;
            end else begin
                state_d    = IDLE;
                switched_d = 1'b1;
            end
        end

        blank_d = (state_d == IDLE);
        gnt_d   = blank_d ? '0 : ({{(N-1){1'b0}}, 1'b1} << sel_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel      <= '0;
            gnt      <= '0;
            blank    <= 1'b1;
            switched <= 1'b0;
            dwell_q  <= '0;
            last_q   <= SW'(N - 1);
        end else begin
            state_q  <= state_d;
            sel      <= sel_d;
            gnt      <= gnt_d;
            blank    <= blank_d;
            switched <= switched_d;
            dwell_q  <= dwell_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: doc/disp_share_sched.md
Name: disp_share_sched

Overview:
- Time-shares the single 8-digit seven-segment display among up to N display sources: game, temperature, and future sources.
- Grants sources in round-robin order, with a dwell of DWELL period ticks per source.
- Supports manual advance (button) and hold.
- Drives the select of the downstream segs_n/an_n/dp_n muxes, plus a blank control when no source requests the display.
- Sits in the lab top level, between period_enb (tick source) and the display muxes.

Parameters:
- N, 4, number of display sources (2..8).
- DWELL, 2, period ticks each source is shown before rotation (1..255).
- SW, $clog2(N), width of sel (derived; do not override).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- tick  input  1  one-cycle enable pulse from period_enb (e.g. PERIOD_MS=2000)
- req  input  N  source i wants the display (level)
- btn_next  input  1  debounced one-cycle pulse; advance to next requester now
- hold  input  1  level; freeze rotation on current source
- sel  output  SW  index of granted source; drives mux select
- gnt  output  N  one-hot grant, all-zero when idle
- blank  output  1  1 = no grant; top forces an_n to all ones
- switched  output  1  one-cycle pulse on the cycle sel/gnt take a new value

Behaviour:
- All outputs registered. Response to any input appears on the clock edge after it is sampled (1-cycle latency).
- Reset (sync, highest priority):
  - state=IDLE, sel=0, gnt=0, blank=1, switched=0, dwell count=0.
  - last-granted pointer=N-1, so the first search starts at index 0.
- Next-requester search: the first i with req[i]=1, scanning from (last+1) mod N upward with wrap, excluding the current source unless it is the only requester.
- States:
  - IDLE:
    - blank=1, gnt=0, sel holds its last value.
    - Any req bit set → SHOW, granting the search result; dwell cleared; switched=1.
  - SHOW:
    - blank=0; gnt=one-hot(sel).
    - Each tick increments dwell. On a tick with dwell==DWELL-1, advance.
  - HOLD:
    - Entered from SHOW when hold=1. Ticks are ignored and dwell is frozen.
    - hold=0 → SHOW with dwell cleared.
- Advance event (SHOW), triggered by any of: dwell expiry, btn_next, or req[sel] deasserted.
  - Another requester exists → grant it, update last, clear dwell, switched=1.
  - Current source is the only requester → keep sel, clear dwell, switched=0.
  - No requester → IDLE, gnt=0, blank=1, switched=1.
- In HOLD, btn_next and dwell expiry are ignored. If req[sel] drops, perform the advance rule; if a new grant results, stay in HOLD when hold=1.
- Simultaneous events in one cycle produce exactly one advance: dwell expiry + btn_next + req drop together move by one source, not two.
- hold and btn_next asserted together in SHOW: hold wins (enter HOLD, no advance).
- rst asserted mid-dwell or in HOLD returns to reset values next edge regardless of other inputs.
- The dwell counter is 8 bits wide and never wraps past DWELL-1.
- With DWELL=1, every tick advances.
- The gnt/sel/blank relation is invariant:
  - blank=1 ⇔ gnt==0.
  - blank=0 ⇒ gnt==1<<sel.
  - gnt is never multi-hot.

Test Plan:
- Reset, then req=4'b0000 for 10 cycles → blank=1, gnt=0, sel=0, switched=0 throughout.
- req=4'b0011, DWELL=2, pulse tick every 5 cycles:
  - Cycle after req rises: gnt=0001, switched=1.
  - After 2nd tick: gnt=0010.
  - After 4th tick: gnt=0001 (wraps).
  - blank=0 throughout.
- req=4'b0101 showing sel=0:
  - btn_next pulse → next cycle sel=2.
  - Drop req[2] → next cycle sel=0, switched=1.
  - Drop req[0] → next cycle IDLE, blank=1, gnt=0.
- Only req[1] set, 6 ticks → sel stays 1, switched never pulses, dwell restarts each expiry.
- req=4'b1111 showing sel=3, hold=1 for 10 ticks → sel stays 3. hold=0 → rotation resumes with sel=0 after DWELL ticks.
- Combined and reset cases:
  - Same cycle tick at expiry + btn_next with sel=0, req=1111 → sel=1 (single step).
  - rst in HOLD → next cycle blank=1, gnt=0, sel=0.
